mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, the number of busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, the number of busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port A  input  32  operand rs (dividend / multiplicand / MTHI-MTLO data).
REQ-006 SHALL have port B  input  32  operand rt (divisor / multiplier).
REQ-007 SHALL have port ctrl  input  3  operation: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
REQ-008 SHALL have port start  input  1  one-cycle request qualifier for ctrl.
REQ-009 SHALL have port busy  output  1  high while an iterative operation is in progress.
REQ-010 SHALL have port HI  output  32  architectural HI register.
REQ-011 SHALL have port LO  output  32  architectural LO register.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV plus a down-counter; busy = (state != IDLE), registered.
REQ-013 In IDLE, start=1 with MULT/MULTU sampled at edge T SHALL latch A, B and signedness and enter MUL; busy high for cycles following edges T..T+MULT_CYCLES-1 (exactly MULT_CYCLES cycles).
REQ-014 DIV/DIVU SHALL behave as REQ-013 with DIV_CYCLES and state DIV.
REQ-015 On edge T+N (N = cycle count) SHALL write HI/LO and return to IDLE; busy low and new HI/LO visible in the same cycle.
REQ-016 MULT SHALL produce the signed 64-bit product, MULTU the unsigned; {HI,LO} = product.
REQ-017 DIV SHALL truncate toward zero: LO = quotient, HI = remainder with the dividend's sign; DIVU unsigned.
REQ-018 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000, with no exception.
REQ-019 Divisor zero (DIV or DIVU) SHALL still run DIV_CYCLES busy cycles and leave HI and LO unchanged.
REQ-020 MTHI/MTLO with start=1 in IDLE SHALL write A into HI/LO at that edge, no busy cycles.
REQ-021 start=1 while busy SHALL be ignored entirely: no operand latch, no HI/LO write, counter undisturbed.
REQ-022 start=1 on the edge busy falls SHALL be ignored too; start is honoured only when state is IDLE at the sampling edge.
REQ-023 start=0 or ctrl none/reserved SHALL leave all state unchanged.
REQ-024 Changes on A/B/ctrl after the start edge SHALL NOT affect an in-flight result.
REQ-025 HI/LO SHALL change only at REQ-015, REQ-020 or reset; they hold their values during busy.

Reset
REQ-026 reset_n=0 SHALL immediately (asynchronously) force state IDLE, counter 0, busy 0, HI 0x00000000, LO 0x00000000.
REQ-027 Reset during MUL/DIV SHALL abort the operation; no result is written after reset_n releases.
REQ-028 First start SHALL be honoured at the first rising edge with reset_n=1.

Verification
REQ-029 MULT A=0xFFFFFFFE (-2), B=0x00000003 -> busy exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-030 DIV A=0xFFFFFFF9 (-7), B=0x00000002 -> busy exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-031 MTHI A=0x12345678 then DIV B=0 -> HI=0x12345678 before and after the 10 busy cycles, LO unchanged.
REQ-032 Start MULT, assert start with MTLO and a new MULT during busy and on the busy-falling edge -> only first result written, no extra busy period, LO not overwritten by MTLO.
REQ-033 Start DIV, pull reset_n low at busy cycle 4 (mid-clock) -> busy, HI, LO zero immediately; after release no write occurs for 10 cycles.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, busy 10 cycles.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative-latency multiply/divide unit with architectural HI/LO registers.
// Operands are latched at the start edge, and the result is committed when the busy count expires.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ctrl,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        opa_q, opa_d, opb_q, opb_d;
    logic               sgn_q, sgn_d;

    logic signed [63:0] opa_w, opb_w, prod;
    logic        [31:0] quot, rem;

    // Sign- or zero-extend to 64 bits so one signed multiply/divide covers both flavours,
    // and so that 0x80000000 / -1 cannot overflow.
    assign opa_w = {{32{sgn_q & opa_q[31]}}, opa_q};
    assign opb_w = {{32{sgn_q & opb_q[31]}}, opb_q};
    assign prod  = opa_w * opb_w;
    assign quot  = 32'(opa_w / opb_w);
    assign rem   = 32'(opa_w % opb_w);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sgn_d   = sgn_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (ctrl)
                        3'b001, 3'b010: begin
                            opa_d   = A;
                            opb_d   = B;
                            sgn_d   = (ctrl == 3'b001);
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            state_d = MUL;
                        end
                        3'b011, 3'b100: begin
                            opa_d   = A;
                            opb_d   = B;
                            sgn_d   = (ctrl == 3'b011);
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                            state_d = DIV;
                        end
                        3'b101:  hi_d = A;
                        3'b110:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV: begin
                if (cnt_q == '0) begin
                    // A zero divisor still burns the full latency but leaves HI/LO untouched.
                    if (opb_q != '0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand latches are pure data and need no reset.
    always_ff @(posedge clk) begin
        opa_q <= opa_d;
        opb_q <= opb_d;
        sgn_q <= sgn_d;
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed and random operations scored
// against a plain-arithmetic model of HI/LO and busy latency.
module tb_mult_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset_n;
    logic [31:0] A, B;
    logic [2:0]  ctrl;
    logic        start;
    logic        busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .A(A), .B(B), .ctrl(ctrl),
        .start(start), .busy(busy), .HI(HI), .LO(LO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int ncycles(input logic [2:0] c);
        case (c)
            3'b001, 3'b010: return MC;
            3'b011, 3'b100: return DC;
            default:        return 0;
        endcase
    endfunction

    function automatic void model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] h0, input logic [31:0] l0,
                                  output logic [31:0] h1, output logic [31:0] l1);
        longint      sq, sr;
        logic [63:0] p, qv, rv;
        h1 = h0;
        l1 = l0;
        case (c)
            3'b001: begin
                sq = longint'($signed(a)) * longint'($signed(b));
                p  = sq;
                h1 = p[63:32];
                l1 = p[31:0];
            end
            3'b010: begin
                p  = {32'b0, a} * {32'b0, b};
                h1 = p[63:32];
                l1 = p[31:0];
            end
            3'b011: if (b != 0) begin
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) % longint'($signed(b));
                qv = sq;
                rv = sr;
                l1 = qv[31:0];
                h1 = rv[31:0];
            end
            3'b100: if (b != 0) begin
                l1 = a / b;
                h1 = a % b;
            end
            3'b101: h1 = a;
            3'b110: l1 = a;
            default: ;
        endcase
    endfunction

    // Issue one request at the next edge, then follow it through its whole busy window.
    task automatic do_op(input string tag, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, input bit noisy);
        int n;
        logic [31:0] nh, nl;
        n = ncycles(c);
        model(c, a, b, exp_hi, exp_lo, nh, nl);
        ctrl  = c;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ctrl  = 3'($urandom);
        A     = $urandom;
        B     = $urandom;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
            chk({tag, "_hold_hi"}, HI, exp_hi);
            chk({tag, "_hold_lo"}, LO, exp_lo);
            if (noisy) begin
                start = 1'b1;
                ctrl  = (i % 2 == 1) ? 3'b110 : 3'b001;
                A     = $urandom;
                B     = $urandom;
            end
            @(posedge clk); #1;
        end
        start  = 1'b0;
        exp_hi = nh;
        exp_lo = nl;
        chk({tag, "_done_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_hi"}, HI, exp_hi);
        chk({tag, "_lo"}, LO, exp_lo);
        if (noisy) begin
            @(posedge clk); #1;
            chk({tag, "_after_busy"}, {31'b0, busy}, 32'd0);
            chk({tag, "_after_hi"}, HI, exp_hi);
            chk({tag, "_after_lo"}, LO, exp_lo);
        end
    endtask

    initial begin
        logic [2:0]  c;
        logic [31:0] a, b;
        reset_n = 1'b0;
        start   = 1'b0;
        ctrl    = 3'b000;
        A       = '0;
        B       = '0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        #3 reset_n = 1'b1;

        // First edge after release must honour the request.
        do_op("first_mtlo", 3'b110, 32'hCAFEF00D, 32'h0, 1'b0);

        do_op("mult_neg", 3'b001, 32'hFFFFFFFE, 32'h00000003, 1'b0);
        chk("mult_neg_const_hi", HI, 32'hFFFFFFFF);
        chk("mult_neg_const_lo", LO, 32'hFFFFFFFA);
        do_op("multu", 3'b010, 32'hFFFFFFFE, 32'h00000003, 1'b0);
        chk("multu_const_hi", HI, 32'h00000002);
        chk("multu_const_lo", LO, 32'hFFFFFFFA);
        do_op("div_neg", 3'b011, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        chk("div_neg_const_lo", LO, 32'hFFFFFFFD);
        chk("div_neg_const_hi", HI, 32'hFFFFFFFF);
        do_op("divu", 3'b100, 32'd7, 32'd2, 1'b0);
        chk("divu_const_lo", LO, 32'd3);
        chk("divu_const_hi", HI, 32'd1);

        do_op("mthi", 3'b101, 32'h12345678, 32'h0, 1'b0);
        chk("mthi_const", HI, 32'h12345678);
        do_op("div_zero", 3'b011, 32'h55AA55AA, 32'h0, 1'b0);
        chk("div_zero_hi", HI, 32'h12345678);
        chk("div_zero_lo", LO, 32'd3);

        do_op("mult_noisy", 3'b001, 32'h00010001, 32'h00020003, 1'b1);

        do_op("div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("div_ovf_const_lo", LO, 32'h80000000);
        chk("div_ovf_const_hi", HI, 32'h00000000);

        do_op("none", 3'b000, 32'hDEADBEEF, 32'h1, 1'b0);
        do_op("reserved", 3'b111, 32'hDEADBEEF, 32'h1, 1'b0);

        for (int k = 0; k < 30; k++) begin
            c = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'h0;
            if ($urandom_range(0, 7) == 0) begin
                a = 32'h80000000;
                b = 32'hFFFFFFFF;
            end
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            do_op("rand", c, a, b, bit'($urandom_range(0, 1)));
        end

        // Make HI/LO non-zero so the asynchronous clear is visible.
        do_op("pre_rst_mthi", 3'b101, 32'hA5A5A5A5, 32'h0, 1'b0);
        do_op("pre_rst_mtlo", 3'b110, 32'h5A5A5A5A, 32'h0, 1'b0);
        ctrl  = 3'b011;
        A     = 32'd100;
        B     = 32'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        chk("abort_busy_before", {31'b0, busy}, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", HI, 32'h0);
        chk("abort_lo", LO, 32'h0);
        exp_hi = '0;
        exp_lo = '0;
        @(posedge clk); #4;
        reset_n = 1'b1;
        for (int i = 0; i < DC + 2; i++) begin
            @(posedge clk); #1;
            chk("post_rst_busy", {31'b0, busy}, 32'd0);
            chk("post_rst_hi", HI, 32'h0);
            chk("post_rst_lo", LO, 32'h0);
        end

        do_op("recover_multu", 3'b010, 32'h89ABCDEF, 32'h01234567, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
